// File: rtl/sync_word_serializer_pkg.sv
// Serial-link constants shared by the sync word serializer and the pattern detector.
// Sync pattern, idle line level and serializer FSM state encodings.
package sync_word_serializer_pkg;

    localparam int unsigned           SER_SYNC_W   = 4;
    localparam logic [SER_SYNC_W-1:0] SER_SYNC_PAT = 4'b0110;
    localparam logic                  SER_IDLE_BIT = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StSync = 3'b001,
        StData = 3'b010,
        StPar  = 3'b011
    } ser_state_e;

    // Bit-index counter width able to address both the sync pattern and the payload.
    function automatic int unsigned ser_cnt_w(input int unsigned data_w,
                                              input int unsigned sync_w);
        int unsigned m;
        m = (data_w > sync_w) ? data_w : sync_w;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_word_serializer_bit_shift_out.sv
// Payload word register with a down-counting bit index and last-bit flag.
// Parity output exists only when SYNC_SER_PARITY_EN is defined.
module sync_word_serializer_bit_shift_out #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_word,
    input  logic [DATA_W-1:0] word_in,
    input  logic              cnt_load,
    input  logic [CNT_W-1:0]  cnt_init,
    input  logic              cnt_dec,
    output logic [CNT_W-1:0]  cnt,
    output logic              data_bit,
    output logic              last
`ifdef SYNC_SER_PARITY_EN
    ,
    output logic              parity
`endif
);

    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (load_word) begin
                word_q <= word_in;
            end
            if (cnt_load) begin
                cnt_q <= cnt_init;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // The index walks from MSB down to bit 0, so the word goes out MSB first.
    assign data_bit = |(word_q & (DATA_W'(1) << cnt_q));
    assign cnt      = cnt_q;
    assign last     = (cnt_q == '0);

`ifdef SYNC_SER_PARITY_EN
    assign parity = ^word_q;
`endif

endmodule

// File: rtl/sync_word_serializer.sv
// Frames parallel words as sync pattern + MSB-first payload on a bit-enable paced line.
// Define SYNC_SER_PARITY_EN to append an even-parity bit after the payload.
module sync_word_serializer
    import sync_word_serializer_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       SYNC_W   = SER_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SER_SYNC_PAT,
    parameter logic              IDLE_BIT = SER_IDLE_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              dout_bit,
    output logic              dout_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int unsigned      CNT_W      = ser_cnt_w(DATA_W, SYNC_W);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(DATA_W - 1);

    ser_state_e       state_q, state_d;
    logic             dout_bit_q, dout_bit_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             data_ready_q, data_ready_d;

    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_init;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             data_bit;
    logic             last;
    logic             sync_bit;
    logic             sync_first;
`ifdef SYNC_SER_PARITY_EN
    logic             parity;
`endif

    sync_word_serializer_bit_shift_out #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_word (accept),
        .word_in   (data_in),
        .cnt_load  (cnt_load),
        .cnt_init  (cnt_init),
        .cnt_dec   (cnt_dec),
        .cnt       (cnt),
        .data_bit  (data_bit),
        .last      (last)
`ifdef SYNC_SER_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    assign accept     = data_valid & data_ready_q;
    assign sync_bit   = |(SYNC_PAT & (SYNC_W'(1) << cnt));
    assign sync_first = (cnt == SYNC_FIRST);

    always_comb begin
        state_d       = state_q;
        dout_bit_d    = dout_bit_q;
        dout_valid_d  = dout_valid_q;
        frame_start_d = 1'b0;
        cnt_load      = 1'b0;
        cnt_init      = '0;
        cnt_dec       = 1'b0;

        case (state_q)
            StIdle: begin
                // The last frame bit stays on the line until the next tick retires it.
                if (bit_en && dout_valid_q) begin
                    dout_bit_d   = IDLE_BIT;
                    dout_valid_d = 1'b0;
                end
                if (accept) begin
                    state_d  = StSync;
                    cnt_load = 1'b1;
                    cnt_init = SYNC_FIRST;
                end
            end
            StSync: begin
                if (bit_en) begin
                    if (sync_first && dout_valid_q) begin
                        // Accepted before the previous frame was retired: idle one period first.
                        dout_bit_d   = IDLE_BIT;
                        dout_valid_d = 1'b0;
                    end else begin
                        dout_bit_d    = sync_bit;
                        dout_valid_d  = 1'b1;
                        frame_start_d = sync_first;
                        if (last) begin
                            state_d  = StData;
                            cnt_load = 1'b1;
                            cnt_init = DATA_FIRST;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
            end
            StData: begin
                if (bit_en) begin
                    dout_bit_d = data_bit;
                    if (last) begin
`ifdef SYNC_SER_PARITY_EN
                        state_d = StPar;
`else
                        state_d = StIdle;
`endif
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
`ifdef SYNC_SER_PARITY_EN
            StPar: begin
                if (bit_en) begin
                    dout_bit_d = parity;
                    state_d    = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        data_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            dout_bit_q    <= IDLE_BIT;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            data_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            dout_bit_q    <= dout_bit_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            data_ready_q  <= data_ready_d;
        end
    end

    assign data_ready  = data_ready_q;
    assign dout_bit    = dout_bit_q;
    assign dout_valid  = dout_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sync_word_serializer.sv
// Directed bench for sync_word_serializer; expectations follow SYNC_SER_PARITY_EN.
module tb_sync_word_serializer;

`ifdef SYNC_SER_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       dout_bit;
    logic       dout_valid;
    logic       frame_start;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic line_q[$];
    logic en_seen = 1'b0;
    int   fs_cnt = 0;
    int   vclk_cnt = 0;
    int   acc_cnt = 0;

    sync_word_serializer #(
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_en      (bit_en),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .dout_bit    (dout_bit),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line monitor: a frame bit is recorded on each tick that leaves dout_valid high.
    always @(posedge clk) en_seen <= bit_en;
    always @(negedge clk) begin
        if (en_seen && dout_valid) line_q.push_back(dout_bit);
        if (frame_start) fs_cnt++;
        if (dout_valid) vclk_cnt++;
        if (data_valid && data_ready) acc_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] gather(input int from);
        logic [63:0] v;
        v = '0;
        for (int k = from; k < line_q.size(); k++) v = {v[62:0], line_q[k]};
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bit_en = 1'b1; data_valid = 1'b0; data_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++; if (dout_bit !== 1'b1) begin
            bad++; $display("FAIL reset_dout_bit: got=%b want=1", dout_bit); end
        total++; if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL reset_dout_valid: got=%b want=0", dout_valid); end
        total++; if (frame_start !== 1'b0) begin
            bad++; $display("FAIL reset_frame_start: got=%b want=0", frame_start); end
        total++; if (data_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_in_reset: got=%b want=0", data_ready); end
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (data_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_before_clk: got=%b want=0", data_ready); end
        @(negedge clk); #1;
        total++; if (data_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_after_clk: got=%b want=1", data_ready); end
    endtask

    task automatic test_frame_a5();
        int s, fs0, v0, a0;
        logic [63:0] exp;
        @(posedge clk); #1;
        s = line_q.size(); fs0 = fs_cnt; v0 = vclk_cnt; a0 = acc_cnt;
        data_in = 8'hA5; data_valid = 1'b1; bit_en = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) data_valid = 1'b0;
            bit_en = (i % 4 == 3);
        end
        @(negedge clk); #1;
        exp = 64'h6A5;
        if (NPAR != 0) exp = {exp[62:0], 1'b0};
        total++; if (gather(s) !== exp) begin
            bad++; $display("FAIL a5_bits: got=%0h want=%0h", gather(s), exp); end
        total++; if (line_q.size() - s !== 12 + NPAR) begin
            bad++; $display("FAIL a5_len: got=%0d want=%0d", line_q.size() - s, 12 + NPAR); end
        total++; if (fs_cnt - fs0 !== 1) begin
            bad++; $display("FAIL a5_frame_start: got=%0d want=1", fs_cnt - fs0); end
        total++; if (vclk_cnt - v0 !== 4 * (12 + NPAR)) begin
            bad++; $display("FAIL a5_valid_clks: got=%0d want=%0d", vclk_cnt - v0,
                            4 * (12 + NPAR)); end
        total++; if ({dout_bit, dout_valid, busy, data_ready} !== 4'b1001) begin
            bad++; $display("FAIL a5_idle_after: got=%b want=1001",
                            {dout_bit, dout_valid, busy, data_ready}); end
    endtask

    task automatic test_back_to_back();
        int s, fs0, a0, gs, gap;
        logic [63:0] exp;
        @(posedge clk); #1;
        s = line_q.size(); fs0 = fs_cnt; a0 = acc_cnt; gs = 0; gap = 0;
        data_in = 8'h00; data_valid = 1'b1; bit_en = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (acc_cnt - a0 >= 1) data_in = 8'hFF;
            if (acc_cnt - a0 >= 2) data_valid = 1'b0;
            @(negedge clk); #1;
            case (gs)
                0: if (dout_valid) gs = 1;
                1: if (!dout_valid) begin gs = 2; gap = 1; end
                2: if (dout_valid) gs = 3; else gap++;
                default: ;
            endcase
        end
        exp = 64'h600;
        if (NPAR != 0) exp = {exp[62:0], 1'b0};
        exp = (exp << 12) | 64'h6FF;
        if (NPAR != 0) exp = {exp[62:0], 1'b0};
        total++; if (gather(s) !== exp) begin
            bad++; $display("FAIL b2b_bits: got=%0h want=%0h", gather(s), exp); end
        total++; if (line_q.size() - s !== 24 + 2 * NPAR) begin
            bad++; $display("FAIL b2b_len: got=%0d want=%0d", line_q.size() - s,
                            24 + 2 * NPAR); end
        total++; if (gap !== 1 || gs !== 3) begin
            bad++; $display("FAIL b2b_gap: got=%0d (phase %0d) want=1", gap, gs); end
        total++; if (acc_cnt - a0 !== 2) begin
            bad++; $display("FAIL b2b_accepts: got=%0d want=2", acc_cnt - a0); end
        total++; if (fs_cnt - fs0 !== 2) begin
            bad++; $display("FAIL b2b_frame_start: got=%0d want=2", fs_cnt - fs0); end
    endtask

    task automatic test_reset_mid_frame();
        int s, fs0, a0;
        logic [63:0] exp;
        @(posedge clk); #1;
        s = line_q.size(); a0 = acc_cnt;
        data_in = 8'h3C; data_valid = 1'b1; bit_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) data_valid = 1'b0;
            @(negedge clk); #1;
            if (line_q.size() - s >= 7) break;
        end
        total++; if (gather(s) !== 64'h31) begin
            bad++; $display("FAIL midrst_bits_before: got=%0h want=31", gather(s)); end
        rst_n = 1'b0;
        #1;
        total++; if ({dout_bit, dout_valid, busy, data_ready} !== 4'b1000) begin
            bad++; $display("FAIL midrst_async_outputs: got=%b want=1000",
                            {dout_bit, dout_valid, busy, data_ready}); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s = line_q.size(); fs0 = fs_cnt; a0 = acc_cnt;
        data_in = 8'h81; data_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) data_valid = 1'b0;
        end
        @(negedge clk); #1;
        exp = 64'h681;
        if (NPAR != 0) exp = {exp[62:0], 1'b0};
        total++; if (gather(s) !== exp) begin
            bad++; $display("FAIL midrst_new_bits: got=%0h want=%0h", gather(s), exp); end
        total++; if (line_q.size() - s !== 12 + NPAR) begin
            bad++; $display("FAIL midrst_new_len: got=%0d want=%0d", line_q.size() - s,
                            12 + NPAR); end
        total++; if (fs_cnt - fs0 !== 1) begin
            bad++; $display("FAIL midrst_frame_start: got=%0d want=1", fs_cnt - fs0); end
    endtask

    task automatic test_stall();
        int s, a0, changes;
        logic reached;
        logic [2:0] snap;
        logic [63:0] exp;
        @(posedge clk); #1;
        s = line_q.size(); a0 = acc_cnt; reached = 1'b0; changes = 0;
        data_in = 8'hC3; data_valid = 1'b1; bit_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) data_valid = 1'b0;
            bit_en = (i % 2 == 1);
            @(negedge clk); #1;
            if (line_q.size() - s >= 6) begin reached = 1'b1; break; end
        end
        total++; if (reached !== 1'b1) begin
            bad++; $display("FAIL stall_reach_data: got=%b want=1", reached); end
        bit_en = 1'b0;
        snap = {dout_bit, dout_valid, busy};
        total++; if (snap[1:0] !== 2'b11) begin
            bad++; $display("FAIL stall_in_frame: got=%b want=11", snap[1:0]); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bit_en = 1'b0;
            @(negedge clk); #1;
            if ({dout_bit, dout_valid, busy} !== snap) changes++;
        end
        total++; if (changes !== 0) begin
            bad++; $display("FAIL stall_hold: got=%0d changed clks want=0", changes); end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            bit_en = (i % 2 == 1);
        end
        @(negedge clk); #1;
        exp = 64'h6C3;
        if (NPAR != 0) exp = {exp[62:0], 1'b0};
        total++; if (gather(s) !== exp) begin
            bad++; $display("FAIL stall_bits: got=%0h want=%0h", gather(s), exp); end
        total++; if (line_q.size() - s !== 12 + NPAR) begin
            bad++; $display("FAIL stall_len: got=%0d want=%0d", line_q.size() - s, 12 + NPAR); end
    endtask

    task automatic test_frame_07();
        int s, a0;
        logic [63:0] exp;
        @(posedge clk); #1;
        s = line_q.size(); a0 = acc_cnt;
        data_in = 8'h07; data_valid = 1'b1; bit_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) data_valid = 1'b0;
        end
        @(negedge clk); #1;
        exp = 64'h607;
        if (NPAR != 0) exp = {exp[62:0], 1'b1};
        total++; if (gather(s) !== exp) begin
            bad++; $display("FAIL f07_bits: got=%0h want=%0h", gather(s), exp); end
        total++; if (line_q.size() - s !== 12 + NPAR) begin
            bad++; $display("FAIL f07_len: got=%0d want=%0d", line_q.size() - s, 12 + NPAR); end
        total++; if ({dout_bit, dout_valid, data_ready} !== 3'b101) begin
            bad++; $display("FAIL f07_idle_after: got=%b want=101",
                            {dout_bit, dout_valid, data_ready}); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_reset_mid_frame();
        test_stall();
        test_frame_07();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
